// File: rtl/accum_dpram_pkg.sv
// rtl/accum_dpram_pkg.sv - shared types for the accumulator RAM
package accum_dpram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        OP_WR  = 1'b0,
        OP_ACC = 1'b1
    } op_e;

endpackage

// File: rtl/accum_dpram_array.sv
// rtl/accum_dpram_array.sv - storage with one write port, an accumulate sample port and a pipelined read port
import accum_dpram_pkg::*;

module accum_dpram_array #(
    parameter int DW     = 32,
    parameter int AW     = 9,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] rmw_addr_i,
    output logic [DW-1:0] rmw_data_o,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rmw_q;
    logic          s1_valid_q;
    logic [DW-1:0] s1_data_q;

    // Both sample ports are read-before-write: a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rmw_q <= mem_q[rmw_addr_i];
    end

    assign rmw_data_o = rmw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_en_i;
            if (rd_en_i) begin
                s1_data_q <= mem_q[rd_addr_i];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_valid_q;
            logic [DW-1:0] s2_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rd_valid_o = s2_valid_q;
            assign rd_data_o  = s2_data_q;
        end else begin : g_lat1
            assign rd_valid_o = s1_valid_q;
            assign rd_data_o  = s1_data_q;
        end
    endgenerate

endmodule

// File: rtl/accum_dpram.sv
// rtl/accum_dpram.sv - accumulator RAM top: clear FSM, read-modify-write pipeline with forwarding
import accum_dpram_pkg::*;

module accum_dpram #(
    parameter int DW         = 32,
    parameter int AW         = 9,
    parameter int RD_LAT     = 2,
    parameter int CLR_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic          wr_acc_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ready_o,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    input  logic          clr_req_i,
    output logic          clr_busy_o
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          w_valid_q;
    op_e           w_op_q;
    logic [AW-1:0] w_addr_q;
    logic [DW-1:0] w_data_q;
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;

    logic          accept;
    logic          fwd_d;
    logic [DW-1:0] rmw_data;
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_next;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign wr_ready_o = (state_q == IDLE);
    assign clr_busy_o = (state_q != IDLE);
    assign accept     = wr_en_i && wr_ready_o;

    // The array sample misses the write committing on the same edge, so
    // that write's result is captured instead when the addresses match.
    assign fwd_d  = w_valid_q && (wr_addr_i == w_addr_q);
    assign w_old  = fwd_q ? fwd_data_q : rmw_data;
    assign w_next = (w_op_q == OP_ACC) ? (w_old + w_data_q) : w_data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = CLEAR;
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_we    = w_valid_q;
        mem_waddr = w_addr_q;
        mem_wdata = w_next;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            cnt_q      <= '0;
            w_valid_q  <= 1'b0;
            w_op_q     <= OP_WR;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_valid_q <= accept;
            if (accept) begin
                w_op_q     <= wr_acc_i ? OP_ACC : OP_WR;
                w_addr_q   <= wr_addr_i;
                w_data_q   <= wr_data_i;
                fwd_q      <= fwd_d;
                fwd_data_q <= w_next;
            end
        end
    end

    accum_dpram_array #(
        .DW     (DW),
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (mem_we),
        .waddr_i    (mem_waddr),
        .wdata_i    (mem_wdata),
        .rmw_addr_i (wr_addr_i),
        .rmw_data_o (rmw_data),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o)
    );

endmodule

// File: tb/tb_accum_dpram.sv
// tb/tb_accum_dpram.sv - self-checking bench for accum_dpram against an in-order array model
module tb_accum_dpram;

    localparam int DW     = 32;
    localparam int AW     = 9;
    localparam int DEPTH  = 1 << AW;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en_i, wr_acc_i, rd_en_i, clr_req_i;
    logic [AW-1:0] wr_addr_i, rd_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_ready_o, rd_valid_o, clr_busy_o;
    logic [DW-1:0] rd_data_o;

    accum_dpram #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .CLR_ON_RST(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_i),
        .wr_acc_i   (wr_acc_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .clr_req_i  (clr_req_i),
        .clr_busy_o (clr_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic          acc;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int            due;
        logic          chk;
        logic [DW-1:0] data;
    } rd_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            busy_from = 0;
    int            busy_to = 0;
    logic          zero_pending = 1'b0;
    logic [DW-1:0] model [DEPTH];
    wr_t           pend[$];
    rd_t           rdq[$];
    logic [DW-1:0] last_rd = '0;
    logic          last_known = 1'b1;

    function automatic logic busy_at(input int c);
        return (c >= busy_from) && (c < busy_to);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // A write accepted in cycle t is visible to reads sampled in cycle t+2.
    task automatic commit();
        wr_t w;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            w = pend.pop_front();
            model[w.addr] = w.acc ? model[w.addr] + w.data : w.data;
        end
        if (zero_pending && cyc >= busy_to) begin
            foreach (model[i]) model[i] = '0;
            zero_pending = 1'b0;
        end
    endtask

    task automatic step();
        logic exp_busy;
        @(negedge clk);
        exp_busy = busy_at(cyc);
        check("clr_busy", clr_busy_o, exp_busy);
        check("wr_ready", wr_ready_o, !exp_busy);
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            check("rd_valid", rd_valid_o, 1);
            if (rdq[0].chk) begin
                check("rd_data", rd_data_o, rdq[0].data);
                last_rd    = rdq[0].data;
                last_known = 1'b1;
            end else begin
                last_known = 1'b0;
            end
            void'(rdq.pop_front());
        end else begin
            check("rd_valid_idle", rd_valid_o, 0);
            if (last_known) check("rd_hold", rd_data_o, last_rd);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic we, input logic acc, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                         input logic clr);
        rd_t r;
        wr_t w;
        commit();
        wr_en_i = we; wr_acc_i = acc; wr_addr_i = wa; wr_data_i = wd;
        rd_en_i = re; rd_addr_i = ra; clr_req_i = clr;
        if (re) begin
            r.due = cyc + RD_LAT; r.chk = !busy_at(cyc); r.data = model[ra];
            rdq.push_back(r);
        end
        if (we && !busy_at(cyc)) begin
            w.due = cyc + 2; w.addr = wa; w.acc = acc; w.data = wd;
            pend.push_back(w);
        end
        if (clr && !busy_at(cyc)) begin
            busy_from    = cyc + 1;
            busy_to      = cyc + 2 + DEPTH;
            zero_pending = 1'b1;
        end
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic read_const(input logic [AW-1:0] ra, input logic [DW-1:0] val);
        rd_t r;
        commit();
        wr_en_i = 1'b0; clr_req_i = 1'b0; rd_en_i = 1'b1; rd_addr_i = ra;
        r.due = cyc + RD_LAT; r.chk = 1'b1; r.data = val;
        rdq.push_back(r);
        step();
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        wr_en_i = 1'b0; wr_acc_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        rd_en_i = 1'b0; rd_addr_i = '0; clr_req_i = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_clr_busy", clr_busy_o, 1);
        check("rst_wr_ready", wr_ready_o, 0);
        rst_n = 1'b1;
        cyc += hold;
        busy_from = cyc; busy_to = cyc + DEPTH; zero_pending = 1'b1;
        rdq.delete(); pend.delete();
        last_rd = '0; last_known = 1'b1;
    endtask

    initial begin
        // Reset sweep: busy for exactly DEPTH cycles, then everything reads 0.
        do_reset(2);
        while (cyc < busy_to) idle();
        read_const(9'd0, 32'h0);
        read_const(9'd511, 32'h0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'($urandom), 1'b0);

        // Overwrite then a back-to-back accumulate chain on one address.
        drive(1'b1, 1'b0, 9'd5, 32'h10, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 9'd5, 32'h1, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 9'd5, 1'b0);
        idle();
        read_const(9'd5, 32'h13);

        // Modulo wrap.
        drive(1'b1, 1'b0, 9'd9, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 9'd9, 32'h2, 1'b0, '0, 1'b0);
        idle(); idle();
        read_const(9'd9, 32'h1);

        // Read-before-write timing.
        drive(1'b1, 1'b0, 9'd7, 32'h77, 1'b0, '0, 1'b0);
        read_const(9'd7, 32'h0);
        read_const(9'd7, 32'h77);

        // Random traffic over a small address set to exercise forwarding.
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 7)),
                  DW'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), 1'b0);
        for (int a = 0; a < 8; a++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(a), 1'b0);

        // Requested clear with a same-cycle write; a second request mid-sweep is ignored.
        drive(1'b1, 1'b0, 9'd3, 32'hAB, 1'b0, '0, 1'b1);
        for (int i = 0; cyc < busy_to; i++)
            drive(1'b0, 1'b0, '0, '0, (i % 3) == 0, AW'($urandom), i == 100);
        read_const(9'd3, 32'h0);
        read_const(9'd5, 32'h0);
        for (int i = 0; i < 40; i++)
            drive($urandom_range(0, 1) != 0, 1'($urandom), AW'($urandom_range(0, 3)),
                  DW'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), 1'b0);

        // Reset pulsed mid-sweep with reads in flight.
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'($urandom), 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_async_rd_valid", rd_valid_o, 0);
        check("rst_async_clr_busy", clr_busy_o, 1);
        do_reset(3);
        while (cyc < busy_to) idle();
        read_const(9'd0, 32'h0);
        read_const(9'd3, 32'h0);
        for (int i = 0; i < 30; i++)
            drive($urandom_range(0, 1) != 0, 1'($urandom), AW'($urandom_range(0, 3)),
                  DW'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), 1'b0);
        repeat (4) idle();
        check("rd_queue_drained", 64'(rdq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
